level_peak_hold: RTL and testbench

//  Consumer of the per-section min/max stream produced upstream in the audio level meter.

---
 rtl/level_peak_hold.sv | 209 ++++++++++++++++++++
 tb/tb_level_peak_hold.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/level_peak_hold.sv
// -----------------------------------------------------------------------------
// level_peak_hold
//
// Takes one (min, max) pair per audio section and works out the section
// amplitude. It converts that amplitude to a log2 bar level (one step per
// 6 dB) and applies peak-hold with stepped decay. It sends (level, peak_level)
// to the display driver.
//
// Processing sequence for each frame:
//   IDLE -> ABS -> SCAN (1..width cycles) -> HOLD -> OUT -> IDLE
//   Latency from the input handshake edge to o_valid = 3 + (width-1-level).
//   The block accepts no new pair while a frame is in flight.
//
// Parameters
//   width        sample width; inputs are two's-complement signed
//   HOLD_FRAMES  frames the peak is held before decay starts (>=1)
//   DECAY_FRAMES frames per one-step peak decrement once hold expires (>=1)
//
// Ports
//   clk           clock
//   reset         asynchronous, active-high reset
//   i_valid       min/max pair valid
//   i_ready       pair can be accepted (high only in IDLE)
//   i_min_value   section minimum (signed)
//   i_max_value   section maximum (signed)
//   o_valid       result valid; held until o_ready
//   o_ready       downstream accepts result
//   o_level       current bar level, 0..width-1
//   o_peak_level  held/decaying peak level, 0..width-1
//   o_clip        full-scale flag; present only when the build defines
//                 LEVEL_METER_CLIP_FLAG_EN
// -----------------------------------------------------------------------------
module level_peak_hold #(
  parameter int width        = 16,
  parameter int HOLD_FRAMES  = 32,
  parameter int DECAY_FRAMES = 4,
  localparam int LW = $clog2(width),
  localparam int HW = $clog2(HOLD_FRAMES + 1),
  localparam int DW = $clog2(DECAY_FRAMES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [width-1:0] i_min_value,
  input  logic [width-1:0] i_max_value,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [LW-1:0]    o_level,
  output logic [LW-1:0]    o_peak_level
`ifdef LEVEL_METER_CLIP_FLAG_EN
  ,
  output logic             o_clip
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABS,
    S_SCAN,
    S_HOLD,
    S_OUT
  } state_t;

  localparam logic [width-1:0] MOST_NEG = {1'b1, {(width-1){1'b0}}};
  localparam logic [width-1:0] MOST_POS = {1'b0, {(width-1){1'b1}}};

  state_t state, state_next;

  logic [width-1:0] min_r, max_r;
  logic [width-2:0] amp;
  logic [LW-1:0]    lvl;
  logic [LW-1:0]    peak, peak_next;
  logic [HW-1:0]    hold_cnt, hold_next;
  logic [DW-1:0]    decay_cnt, decay_next;
  logic [width-2:0] abs_max, abs_min;
  logic             scan_done;

  // The magnitude of the most negative code does not fit in width-1 bits.
  // Clamp it to full scale so that it reads as the loudest level.
  function automatic logic [width-2:0] abs_sat(input logic [width-1:0] v);
    logic [width-1:0] neg;
    neg = -v;
    if (!v[width-1])    return v[width-2:0];
    if (v == MOST_NEG)  return '1;
    return neg[width-2:0];
  endfunction

  assign abs_max   = abs_sat(max_r);
  assign abs_min   = abs_sat(min_r);
  assign scan_done = amp[width-2] || (lvl == '0);
  assign i_ready   = (state == S_IDLE);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: every combinational output gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (i_valid)   state_next = S_ABS;
      S_ABS:                 state_next = S_SCAN;
      S_SCAN: if (scan_done) state_next = S_HOLD;
      S_HOLD:                state_next = S_OUT;
      S_OUT:  if (o_ready)   state_next = S_IDLE;
      default:               state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Peak-hold update. A new level at or above the peak re-arms the hold.
  // Otherwise the hold counts down first, and after that the peak drops by one
  // step every DECAY_FRAMES frames. On that branch peak > lvl, so the peak
  // can never fall below the current level.
  // ---------------------------------------------------------------------------
  always_comb begin
    peak_next  = peak;
    hold_next  = hold_cnt;
    decay_next = decay_cnt;
    if (lvl >= peak) begin
      peak_next  = lvl;
      hold_next  = HW'(HOLD_FRAMES);
      decay_next = DW'(DECAY_FRAMES);
    end else if (hold_cnt != '0) begin
      hold_next  = hold_cnt - HW'(1);
    end else if (decay_cnt == DW'(1)) begin
      peak_next  = peak - LW'(1);
      decay_next = DW'(DECAY_FRAMES);
    end else begin
      decay_next = decay_cnt - DW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // NOTE: state registers are updated with non-blocking assignments. All of
  // them then sample pre-edge values, whatever order the statements are in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      min_r        <= '0;
      max_r        <= '0;
      amp          <= '0;
      lvl          <= '0;
      peak         <= '0;
      hold_cnt     <= '0;
      decay_cnt    <= DW'(DECAY_FRAMES);
      o_valid      <= 1'b0;
      o_level      <= '0;
      o_peak_level <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (i_valid) begin
            min_r <= i_min_value;
            max_r <= i_max_value;
          end
        end
        S_ABS: begin
          amp <= (abs_max > abs_min) ? abs_max : abs_min;
          lvl <= LW'(width - 1);
        end
        S_SCAN: begin
          // Normalise amp until its top bit is set. The number of shifts
          // taken gives the log2 level.
          if (!scan_done) begin
            amp <= amp << 1;
            lvl <= lvl - LW'(1);
          end
        end
        S_HOLD: begin
          peak         <= peak_next;
          hold_cnt     <= hold_next;
          decay_cnt    <= decay_next;
          o_level      <= lvl;
          o_peak_level <= peak_next;
          o_valid      <= 1'b1;
        end
        S_OUT: begin
          if (o_ready) o_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef LEVEL_METER_CLIP_FLAG_EN
  // The clip flag is captured from the registered pair and published together
  // with the frame result.
  logic clip_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clip_r <= 1'b0;
      o_clip <= 1'b0;
    end else begin
      if (state == S_ABS)  clip_r <= (max_r == MOST_POS) || (min_r == MOST_NEG);
      if (state == S_HOLD) o_clip <= clip_r;
    end
  end
`endif

endmodule

// File: tb/tb_level_peak_hold.sv
// -----------------------------------------------------------------------------
// Directed testbench for level_peak_hold (width=16, HOLD_FRAMES=32,
// DECAY_FRAMES=4). Expected levels, peaks and latencies are worked out by hand
// from the level/peak-hold rules.
// -----------------------------------------------------------------------------
module tb_level_peak_hold;

  localparam int W  = 16;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_valid;
  logic          i_ready;
  logic [W-1:0]  i_min_value;
  logic [W-1:0]  i_max_value;
  logic          o_valid;
  logic          o_ready;
  logic [LW-1:0] o_level;
  logic [LW-1:0] o_peak_level;
  logic          o_clip;

  int checks = 0;
  int errors = 0;

  level_peak_hold #(
    .width        (W),
    .HOLD_FRAMES  (32),
    .DECAY_FRAMES (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_valid      (i_valid),
    .i_ready      (i_ready),
    .i_min_value  (i_min_value),
    .i_max_value  (i_max_value),
    .o_valid      (o_valid),
    .o_ready      (o_ready),
    .o_level      (o_level),
    .o_peak_level (o_peak_level)
`ifdef LEVEL_METER_CLIP_FLAG_EN
    ,
    .o_clip       (o_clip)
`endif
  );

`ifndef LEVEL_METER_CLIP_FLAG_EN
  assign o_clip = 1'b0;
`endif

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sends one pair and waits, with a bound, for o_valid. On return the time
  // is 1 ns after the edge that raised o_valid. busy_rdy reports whether
  // i_ready was seen high while the frame was in flight.
  task automatic send_frame(input logic [W-1:0] mx, input logic [W-1:0] mn,
                            output logic [LW-1:0] lvl, output logic [LW-1:0] pk,
                            output int lat, output logic clip, output logic busy_rdy);
    int wait_cnt;
    @(negedge clk);
    i_max_value = mx;
    i_min_value = mn;
    i_valid     = 1'b1;
    wait_cnt    = 0;
    while (!i_ready && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    @(posedge clk);
    #1;
    i_valid  = 1'b0;
    lat      = 0;
    busy_rdy = 1'b0;
    while (!o_valid && lat < 40) begin
      busy_rdy = busy_rdy | i_ready;
      @(posedge clk);
      lat++;
      #1;
    end
    busy_rdy = busy_rdy | i_ready;
    lvl      = o_level;
    pk       = o_peak_level;
    clip     = o_clip;
  endtask

  initial begin
    logic [LW-1:0] lvl, pk, lvl0, pk0;
    logic          clip, busy;
    logic          stable;
    int            lat;
    int            transfers;

    reset       = 1'b1;
    i_valid     = 1'b0;
    i_min_value = '0;
    i_max_value = '0;
    o_ready     = 1'b1;

    // Reset state
    #12;
    check("reset_i_ready", i_ready, 1);
    check("reset_o_valid", o_valid, 0);
    check("reset_o_level", o_level, 0);
    check("reset_o_peak",  o_peak_level, 0);
`ifdef LEVEL_METER_CLIP_FLAG_EN
    check("reset_o_clip", o_clip, 0);
`endif
    @(negedge clk);
    reset = 1'b0;

    // Frame 1: positive full scale -> level 15, minimum latency
    send_frame(16'h7FFF, 16'h0000, lvl, pk, lat, clip, busy);
    check("f1_level", lvl, 15);
    check("f1_peak",  pk, 15);
    check("f1_latency", lat, 3);
`ifdef LEVEL_METER_CLIP_FLAG_EN
    check("f1_clip", clip, 1);
`endif
    @(posedge clk); #1;

    // Frame 2: zero amplitude -> level 0, maximum latency, busy the whole time
    send_frame(16'h0000, 16'h0000, lvl, pk, lat, clip, busy);
    check("f2_level", lvl, 0);
    check("f2_peak",  pk, 15);
    check("f2_latency", lat, 18);
    check("f2_i_ready_busy", busy, 0);
    @(posedge clk); #1;
    check("f2_o_valid_after_hs", o_valid, 0);
    check("f2_i_ready_after_hs", i_ready, 1);

    // Frames 3..41: zeros. The hold runs out, then the peak decays every 4 frames.
    for (int f = 3; f <= 41; f++) begin
      send_frame(16'h0000, 16'h0000, lvl, pk, lat, clip, busy);
      @(posedge clk); #1;
      if (f == 3)  check("f3_peak",  pk, 15);
      if (f == 36) check("f36_peak", pk, 15);
      if (f == 37) check("f37_peak", pk, 14);
      if (f == 41) check("f41_peak", pk, 13);
    end

    // Frame 42: max=1, min=-1 -> level 1, latency 17; decay counter only
    send_frame(16'h0001, 16'hFFFF, lvl, pk, lat, clip, busy);
    check("f42_level", lvl, 1);
    check("f42_latency", lat, 17);
    check("f42_peak", pk, 13);
`ifdef LEVEL_METER_CLIP_FLAG_EN
    check("f42_clip", clip, 0);
`endif
    @(posedge clk); #1;

    // Frame 43: most negative min saturates to full scale
    send_frame(16'h0000, 16'h8000, lvl, pk, lat, clip, busy);
    check("f43_level", lvl, 15);
    check("f43_peak", pk, 15);
    check("f43_latency", lat, 3);
`ifdef LEVEL_METER_CLIP_FLAG_EN
    check("f43_clip", clip, 1);
`endif
    @(posedge clk); #1;

    // Frame 44: backpressure for 10 cycles in OUT
    o_ready = 1'b0;
    send_frame(16'h0100, 16'h0000, lvl0, pk0, lat, clip, busy);
    check("f44_level", lvl0, 9);
    check("f44_peak", pk0, 15);
    check("f44_latency", lat, 9);
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (!o_valid || o_level !== lvl0 || o_peak_level !== pk0 || i_ready) stable = 1'b0;
    end
    check("bp_outputs_stable", stable, 1);
    @(negedge clk);
    o_ready   = 1'b1;
    transfers = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      if (o_valid && o_ready) transfers++;
      #1;
    end
    check("bp_single_transfer", transfers, 1);
    check("bp_i_ready_after", i_ready, 1);

    // Reset pulsed while a zero-amplitude frame is in SCAN
    @(negedge clk);
    i_max_value = '0;
    i_min_value = '0;
    i_valid     = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rst_mid_o_valid", o_valid, 0);
    check("rst_mid_i_ready", i_ready, 1);
    check("rst_mid_o_peak", o_peak_level, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_i_ready_next", i_ready, 1);
    check("rst_mid_no_output", o_valid, 0);

    // The peak was 15 before the reset. A new level-9 frame must show peak 9.
    send_frame(16'h0100, 16'h0000, lvl, pk, lat, clip, busy);
    check("post_rst_level", lvl, 9);
    check("post_rst_peak", pk, 9);
    check("post_rst_latency", lat, 9);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
